// File: rtl/square_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : square_dispatch
//  Purpose  : Initiator for the single-job worker handshake (ready/busy/valid).
//             Accepts operands from an upstream valid/ready stream, launches
//             one job at a time on the worker, holds the operand stable until
//             the result returns, and queues results in a show-ahead FIFO for
//             a downstream valid/ready consumer.
//  Ports    : clk_in, rst_n_in (async, active-low)
//             in_valid_in / in_data_in / in_ready_out   upstream operand stream
//             wk_ready_out / wk_value_out               start + operand to worker
//             wk_busy_in / wk_valid_in / wk_result_in   worker status and result
//             out_valid_out / out_data_out / out_ready_in  result stream (FIFO)
//             err_out                                   sticky watchdog error
//  Options  : define SQD_TIMEOUT_EN to build the worker watchdog
//             (TIMEOUT_CYCLES); otherwise err_out is tied low and the
//             dispatcher waits indefinitely for the worker.
//  Revision : 1.0  initial release
// ============================================================================
module square_dispatch #(
    parameter int WIDTH          = 16,
    parameter int RWIDTH         = 16,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              in_valid_in,
    input  logic [WIDTH-1:0]  in_data_in,
    output logic              in_ready_out,
    output logic              wk_ready_out,
    output logic [WIDTH-1:0]  wk_value_out,
    input  logic              wk_busy_in,
    input  logic              wk_valid_in,
    input  logic [RWIDTH-1:0] wk_result_in,
    output logic              out_valid_out,
    output logic [RWIDTH-1:0] out_data_out,
    input  logic              out_ready_in,
    output logic              err_out
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_value;
    logic [RWIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic w_inflight;
    logic w_space;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_abort;
    logic w_tmo_hit;

    // A job in START/WAIT owns a reserved FIFO slot, so a result push can
    // never overflow. A pop in the current cycle is deliberately not credited.
    assign w_inflight = (r_state != ST_IDLE);
    assign w_space    = (int'(r_count) + int'(w_inflight)) < DEPTH;

    // Gated by the reset pin so the upstream sees no readiness while reset
    // is held, even though the registers already read as IDLE/empty.
    assign in_ready_out = rst_n_in && (r_state == ST_IDLE) && w_space;
    assign w_accept     = in_valid_in && in_ready_out;

    assign wk_ready_out = (r_state == ST_START);
    assign wk_value_out = r_value;

    assign out_valid_out = (r_count != '0);
    assign out_data_out  = out_valid_out ? r_mem[r_rd_ptr] : '0;
    assign w_pop         = out_valid_out && out_ready_in;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (wk_busy_in) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (wk_valid_in) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand is captured only on accept, so it stays put for the whole job.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_value <= '0;
        end else if (w_accept) begin
            r_value <= in_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (show-ahead)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wk_result_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional worker watchdog
    // ------------------------------------------------------------------
`ifdef SQD_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    // Abort fires on the edge where the count would reach TIMEOUT_CYCLES,
    // i.e. after exactly TIMEOUT_CYCLES cycles spent in START/WAIT.
    assign w_tmo_hit = w_inflight && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_out   = r_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tmo_cnt <= '0;
            end else if (w_inflight) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign err_out   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_square_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_square_dispatch
//  Purpose  : Scoreboard bench for square_dispatch with a model square worker.
//             Expected results are pushed when an operand is accepted; a
//             monitor pops and compares on every downstream pop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_square_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        wk_ready;
    logic [15:0] wk_value;
    logic        wk_busy;
    logic        wk_valid;
    logic [15:0] wk_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] sb[$];

    // model worker controls
    logic        wk_en = 1'b1;
    logic        stray = 1'b0;
    logic        wm_busy;
    logic        wm_valid;
    logic [15:0] wm_v;
    logic [15:0] wm_res;

    square_dispatch #(
        .WIDTH(16), .RWIDTH(16), .DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .in_valid_in(in_valid), .in_data_in(in_data), .in_ready_out(in_ready),
        .wk_ready_out(wk_ready), .wk_value_out(wk_value),
        .wk_busy_in(wk_busy), .wk_valid_in(wk_valid), .wk_result_in(wk_result),
        .out_valid_out(out_valid), .out_data_out(out_data), .out_ready_in(out_ready),
        .err_out(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model square worker: busy for one cycle after seeing ready, then a
    // one-cycle valid pulse carrying the truncated square.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wm_busy  <= 1'b0;
            wm_valid <= 1'b0;
            wm_v     <= '0;
            wm_res   <= '0;
        end else begin
            wm_valid <= 1'b0;
            if (wm_busy) begin
                wm_busy  <= 1'b0;
                wm_valid <= 1'b1;
                wm_res   <= 16'(wm_v * wm_v);
            end else if (wk_en && wk_ready && !wm_valid) begin
                wm_busy <= 1'b1;
                wm_v    <= wk_value;
            end
        end
    end
    assign wk_busy   = wm_busy;
    assign wk_valid  = wm_valid | stray;
    assign wk_result = stray ? 16'hDEAD : wm_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {16'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("result", {16'h0, out_data}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Offer one operand; returns just after the accept edge (posedge + 1).
    task automatic send(input logic [15:0] op, input logic [15:0] exp,
                        input bit hold, input bit push_exp, output int acc);
        bit done = 1'b0;
        acc      = -1;
        in_valid = 1'b1;
        in_data  = op;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push_exp) sb.push_back(exp);
                @(posedge clk);
                #1;
                acc  = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            check("send_timeout", 32'h0, 32'h1);
            @(posedge clk);
            #1;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) cycles(1);
        check("drain_empty", sb.size(), 0);
    endtask

    int a0, a1, a2, dummy;

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_wk_ready", wk_ready, 0);
        check("rst_wk_value", wk_value, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        cycles(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // ---------------- single job ----------------
        out_ready = 1'b1;
        send(16'h0003, 16'h0009, 0, 1, a0);
        check("single_wk_ready_c0", wk_ready, 1);
        check("single_wk_value", wk_value, 16'h0003);
        cycles(1);
        check("single_wk_ready_c1", wk_ready, 1);
        cycles(1);
        check("single_wk_ready_c2", wk_ready, 0);
        check("single_out_valid_c2", out_valid, 0);
        cycles(1);
        check("single_out_valid_c3", out_valid, 1);
        check("single_out_data_c3", out_data, 16'h0009);
        drain();

        // ---------------- stray worker valid in IDLE ----------------
        stray = 1'b1;
        cycles(1);
        stray = 1'b0;
        cycles(1);
        check("stray_no_push", out_valid, 0);

        // ---------------- back-to-back stream ----------------
        send(16'h0002, 16'h0004, 1, 1, a0);
        send(16'h00FF, 16'hFE01, 1, 1, a1);
        send(16'hFFFF, 16'h0001, 0, 1, a2);
        check("b2b_gap1", a1 - a0, 4);
        check("b2b_gap2", a2 - a1, 4);
        drain();

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 1, 1, dummy);
        send(16'h0004, 16'h0010, 1, 1, dummy);
        send(16'h0008, 16'h0040, 1, 1, dummy);
        send(16'h0010, 16'h0100, 1, 1, dummy);
        in_data = 16'h0011;
        cycles(20);
        check("bp_blocked", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head", out_data, 16'h0001);
        out_ready = 1'b1;
        send(16'h0011, 16'h0121, 1, 1, dummy);
        send(16'h0100, 16'h0000, 0, 1, dummy);
        drain();

        // ---------------- simultaneous push and pop ----------------
        out_ready = 1'b0;
        send(16'h0005, 16'h0019, 0, 1, dummy);
        cycles(4);
        check("pp_one_entry", out_valid, 1);
        send(16'h0007, 16'h0031, 0, 1, dummy);
        for (int k = 0; k < 20 && !wk_valid; k++) cycles(1);
        check("pp_push_seen", wk_valid, 1);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("pp_count_stays", out_valid, 1);
        check("pp_order", out_data, 16'h0031);
        drain();

        // ---------------- reset mid-job ----------------
        out_ready = 1'b0;
        send(16'h0004, 16'h0010, 0, 1, dummy);
        cycles(4);
        send(16'h0006, 16'h0024, 0, 1, dummy);
        cycles(2);
        check("mid_value_held", wk_value, 16'h0006);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wk_ready", wk_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        cycles(2);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_ready", in_ready, 1);
        out_ready = 1'b1;
        send(16'h0010, 16'h0100, 0, 1, dummy);
        drain();

`ifdef SQD_TIMEOUT_EN
        // ---------------- watchdog ----------------
        wk_en = 1'b0;
        send(16'h0002, 16'h0004, 0, 0, dummy);
        cycles(7);
        check("tmo_err_before", err, 0);
        cycles(1);
        check("tmo_err_set", err, 1);
        check("tmo_in_ready", in_ready, 1);
        check("tmo_no_push", out_valid, 0);
        wk_en = 1'b1;
        send(16'h0003, 16'h0009, 0, 1, dummy);
        drain();
        check("tmo_err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_dispatch.md
Name: square_dispatch

Overview:
- Initiator for the team's single-job worker handshake (ready / busy / valid), the other end of the `square` worker.
- Accepts operands from an upstream valid/ready stream and launches one job at a time on the worker.
- Holds the operand stable until the worker returns, then queues results in a small show-ahead FIFO for a downstream valid/ready consumer.
- Sits between the sample source and the worker; owns all flow control toward the worker.

Parameters:
- WIDTH, 16, operand width (in_data_in, wk_value_out).
- RWIDTH, 16, result width (wk_result_in, out_data_out).
- DEPTH, 4, result FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 64, worker watchdog limit; used only with SQD_TIMEOUT_EN.

Ports:
- clk_in  input  1  sole clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- in_valid_in  input  1  upstream operand valid.
- in_data_in  input  WIDTH  upstream operand.
- in_ready_out  output  1  dispatcher can accept an operand.
- wk_ready_out  output  1  start request to the worker's ready input.
- wk_value_out  output  WIDTH  held operand to the worker's value input.
- wk_busy_in  input  1  worker busy.
- wk_valid_in  input  1  worker result-valid pulse.
- wk_result_in  input  RWIDTH  worker result.
- out_valid_out  output  1  FIFO non-empty.
- out_data_out  output  RWIDTH  FIFO head.
- out_ready_in  input  1  downstream pop.
- err_out  output  1  sticky watchdog error.

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in; all state is cleared on assertion.
- Reset values: state=IDLE; wk_ready_out=0; wk_value_out=0; FIFO empty (out_valid_out=0, out_data_out=0); err_out=0; in_ready_out=0 while reset is asserted.
- Space rule: space = (fifo_count + inflight) < DEPTH.
  - inflight=1 in any state other than IDLE.
  - Uses the registered count; a same-cycle pop is not credited (conservative).
- in_ready_out = (state==IDLE) && space. This is combinational from registers only; no dependency on in_valid_in.
- FSM:
  - IDLE: on in_valid_in && in_ready_out, capture in_data_in into wk_value_out and go to START.
  - START: wk_ready_out=1 (Moore). When wk_busy_in=1 is sampled, go to WAIT.
  - WAIT: wk_ready_out=0. When wk_valid_in=1 is sampled, push wk_result_in into the FIFO and go to IDLE.
- wk_ready_out is deasserted from the cycle after busy is seen, so the worker is never re-triggered when its busy falls.
- wk_value_out must not change between accept and the result push.
- Latency with a conforming worker:
  - Accept edge E0.
  - wk_ready_out high in cycle E0+.
  - Worker busy at E1.
  - State WAIT at E2; worker valid in cycle E2+.
  - Push at E3; out_valid_out=1 in cycle E3+.
  - Next accept no earlier than E4, giving a throughput of one job per 4 cycles.
- FIFO:
  - Show-ahead: out_data_out is the head whenever out_valid_out=1.
  - Pop on out_valid_out && out_ready_in.
  - Push and pop in the same cycle leave the count unchanged; the pushed data is ordered after the head.
  - Pointers wrap modulo DEPTH.
  - Overflow cannot occur by construction of the space rule.
- Stray inputs: wk_valid_in in IDLE or START is ignored and nothing is pushed. wk_busy_in in IDLE is ignored.
- Reset mid-job: the FSM returns to IDLE, the FIFO is flushed, and wk_ready_out drops immediately (asynchronously).
- Downstream stall: a full FIFO blocks new accepts. The in-flight job always has a reserved slot.

Optional Feature:
- Macro: SQD_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to START and increments in START/WAIT.
  - On reaching TIMEOUT_CYCLES, the FSM aborts to IDLE with wk_ready_out=0, pushes nothing, and sets err_out=1 (sticky until reset).
  - A late wk_valid_in after an abort is ignored.
- When not defined: no counter is built, err_out is tied to 0, and the dispatcher waits indefinitely.

Test Plan:
- Single job: operand 0x0003 with a model `square` worker and out_ready_in=1 → out_data_out=0x0009 with out_valid_out high exactly 3 cycles after the accept edge; wk_ready_out high for exactly 2 cycles.
- Back-to-back stream: 0x0002, 0x00FF, 0xFFFF with in_valid_in held high → results 0x0004, 0xFE01, 0x0001 in order; accepts spaced 4 cycles apart.
- Backpressure with DEPTH=4: out_ready_in=0 and 6 operands offered → exactly 4 accepted, then in_ready_out=0. Raise out_ready_in → all results drain in order and accepts resume.
- Simultaneous push and pop: FIFO holding 1 entry while a push and a pop coincide → count stays 1 and order is preserved.
- Reset mid-job: deassert rst_n_in while in WAIT → wk_ready_out=0, out_valid_out=0 and in_ready_out=0 immediately. After release, in_ready_out=1 and a new job completes correctly.
- With SQD_TIMEOUT_EN, TIMEOUT_CYCLES=8: worker never asserts busy → err_out=1 after 8 cycles, no result pushed, in_ready_out=1 again.
